// File: rtl/fp_pkg.sv
// -----------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the pipelined IEEE-754 adder/subtractor:
//   - default exponent / fraction widths
//   - status flag bit positions inside the 4-bit flag word
//   - operand class enum and a width-independent classifier
//   - constant functions building the +Inf and canonical qNaN bit patterns
// No ports (package).
// -----------------------------------------------------------------------------
package fp_pkg;

   localparam int EXP_W_DEF = 8;
   localparam int MAN_W_DEF = 23;

   // Bit positions inside out_flags = {invalid, overflow, underflow, inexact}
   localparam int FLG_INV = 3;
   localparam int FLG_OVF = 2;
   localparam int FLG_UNF = 1;
   localparam int FLG_INX = 0;

   // Widest packed word the constant functions can describe
   localparam int MAX_W = 64;

   typedef enum logic [2:0] {ZERO, SUB, NORM, INF, QNAN, SNAN} fp_class_e;

   // +Inf magnitude: sign 0, exponent all ones, fraction 0
   function automatic logic [MAX_W-1:0] fp_inf(input int exp_w, input int man_w);
      logic [MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < exp_w; i++) r[man_w + i] = 1'b1;
      return r;
   endfunction

   // Canonical quiet NaN: +Inf pattern with the fraction MSB set
   function automatic logic [MAX_W-1:0] fp_qnan(input int exp_w, input int man_w);
      logic [MAX_W-1:0] r;
      r = fp_inf(exp_w, man_w);
      r[man_w - 1] = 1'b1;
      return r;
   endfunction

   // Classifies an operand from a few field summaries so it works for any width
   function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                             input logic frac_zero, input logic frac_msb);
      fp_class_e c;
      if (exp_ones)      c = frac_zero ? INF : (frac_msb ? QNAN : SNAN);
      else if (exp_zero) c = frac_zero ? ZERO : SUB;
      else               c = NORM;
      return c;
   endfunction

endpackage

// File: rtl/fp_addsub_pipe_if.sv
// -----------------------------------------------------------------------------
// fp_addsub_pipe_if
// Operand-issue and result-writeback handshake bundle of fp_addsub_pipe.
//   in_valid/in_ready   operand pair transfer (in_a, in_b, in_op)
//   out_valid/out_ready result transfer (out_result, out_flags)
// Modports: master = operand producer / result consumer, slave = the adder.
// -----------------------------------------------------------------------------
interface fp_addsub_pipe_if #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
);
   localparam int W = 1 + EXP_W + MAN_W;

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         in_op;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic [3:0]   out_flags;

   modport master (
      output in_valid, in_a, in_b, in_op, out_ready,
      input  in_ready, out_valid, out_result, out_flags
   );

   modport slave (
      input  in_valid, in_a, in_b, in_op, out_ready,
      output in_ready, out_valid, out_result, out_flags
   );
endinterface

// File: rtl/fp_lzc.sv
// -----------------------------------------------------------------------------
// fp_lzc
// Leading-zero counter used by the normalisation stage.
//   din   [WIDTH-1:0]  vector to scan, MSB first
//   count [CNT_W-1:0]  number of zeros above the highest set bit (WIDTH if din==0)
// -----------------------------------------------------------------------------
module fp_lzc #(
   parameter int WIDTH = 25,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic [WIDTH-1:0] din,
   output logic [CNT_W-1:0] count
);

   // Scanning upward lets the highest set bit overwrite any lower hit.
   always_comb begin
      count = CNT_W'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (din[i]) count = CNT_W'(WIDTH - 1 - i);
      end
   end

endmodule

// File: rtl/fp_addsub_pipe.sv
// -----------------------------------------------------------------------------
// fp_addsub_pipe
// Three-stage pipelined IEEE-754 adder/subtractor, round-to-nearest-even.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; discards in-flight operations
//   bus    fp_addsub_pipe_if.slave:
//          in_valid/in_ready/in_a/in_b/in_op   (in_op: 0 = A+B, 1 = A-B)
//          out_valid/out_ready/out_result/out_flags {inv, ovf, unf, inx}
// Stages: S1 unpack/classify/swap/align, S2 add/subtract,
//         S3 normalise/round/pack into the output register.
// One global advance enable: every stage moves only when the output is free.
// -----------------------------------------------------------------------------
module fp_addsub_pipe
   import fp_pkg::*;
#(
   parameter int EXP_W = EXP_W_DEF,
   parameter int MAN_W = MAN_W_DEF
) (
   input logic             clk,
   input logic             rst_n,
   fp_addsub_pipe_if.slave bus
);

   localparam int W    = 1 + EXP_W + MAN_W;
   localparam int SW   = MAN_W + 1;        // significand incl. hidden bit
   localparam int AW   = MAN_W + 4;        // significand + guard/round/sticky
   localparam int SUMW = MAN_W + 5;        // plus carry
   localparam int XW   = 2 * (MAN_W + 3);  // alignment window incl. shifted-out bits
   localparam int LZW  = MAN_W + 2;
   localparam int CW   = $clog2(LZW + 1);

   localparam logic [EXP_W-1:0] EXP_ONES = '1;
   localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
   localparam logic [EXP_W:0]   EXPX_ONE = (EXP_W + 1)'(1);
   localparam logic [W-1:0]     INF_MAG  = W'(fp_inf(EXP_W, MAN_W));
   localparam logic [W-1:0]     QNAN_W   = W'(fp_qnan(EXP_W, MAN_W));

   logic adv;
   logic out_valid_q;
   logic [W-1:0] out_result_q;
   logic [3:0]   out_flags_q;

   assign adv           = !out_valid_q || bus.out_ready;
   assign bus.in_ready  = adv;
   assign bus.out_valid  = out_valid_q;
   assign bus.out_result = out_result_q;
   assign bus.out_flags  = out_flags_q;

   // ---------------------------------------------------------------- S1
   logic             a_sign, b_sign;
   logic [EXP_W-1:0] a_exp, b_exp;
   logic [MAN_W-1:0] a_frac, b_frac;
   fp_class_e        a_cls, b_cls;

   assign a_sign = bus.in_a[W-1];
   assign a_exp  = bus.in_a[W-2:MAN_W];
   assign a_frac = bus.in_a[MAN_W-1:0];
   assign b_sign = bus.in_b[W-1] ^ bus.in_op;   // subtract = add with B negated
   assign b_exp  = bus.in_b[W-2:MAN_W];
   assign b_frac = bus.in_b[MAN_W-1:0];

   assign a_cls = fp_classify(a_exp == '0, a_exp == EXP_ONES, a_frac == '0, a_frac[MAN_W-1]);
   assign b_cls = fp_classify(b_exp == '0, b_exp == EXP_ONES, b_frac == '0, b_frac[MAN_W-1]);

   logic             l_sign;
   logic [EXP_W-1:0] l_exp, s_exp, l_eexp, s_eexp, d;
   logic [MAN_W-1:0] l_frac, s_frac;
   logic [SW-1:0]    l_sig, s_sig;
   logic [XW-1:0]    s_ext;
   logic [AW-1:0]    big_d, small_d;
   logic             spec_d;
   logic [W-1:0]     spec_res_d;
   logic [3:0]       spec_flags_d;

   // NOTE: every signal of a combinational block gets a default first, so no path can infer a latch.
   always_comb begin
      l_sign = a_sign;
      l_exp  = a_exp;
      l_frac = a_frac;
      s_exp  = b_exp;
      s_frac = b_frac;
      // Packed {exp, frac} orders magnitudes, so one compare decides the swap.
      if ({b_exp, b_frac} > {a_exp, a_frac}) begin
         l_sign = b_sign;
         l_exp  = b_exp;
         l_frac = b_frac;
         s_exp  = a_exp;
         s_frac = a_frac;
      end

      // Subnormals use effective exponent 1 with a zero hidden bit.
      l_eexp = (l_exp == '0) ? EXP_ONE : l_exp;
      s_eexp = (s_exp == '0) ? EXP_ONE : s_exp;
      l_sig  = {l_exp != '0, l_frac};
      s_sig  = {s_exp != '0, s_frac};
      d      = l_eexp - s_eexp;

      // Lower half of the window catches everything shifted past the round bit.
      s_ext = {s_sig, 2'b00, {(MAN_W + 3){1'b0}}} >> d;
      big_d = {l_sig, 3'b000};
      if (int'(d) >= MAN_W + 3) small_d = {{(MAN_W + 3){1'b0}}, s_sig != '0};
      else                      small_d = {s_ext[XW-1:MAN_W+3], |s_ext[MAN_W+2:0]};

      spec_d       = 1'b0;
      spec_res_d   = '0;
      spec_flags_d = '0;
      if (a_cls inside {QNAN, SNAN} || b_cls inside {QNAN, SNAN}) begin
         spec_d                = 1'b1;
         spec_res_d            = QNAN_W;
         spec_flags_d[FLG_INV] = (a_cls == SNAN) || (b_cls == SNAN);
      end else if (a_cls == INF && b_cls == INF && a_sign != b_sign) begin
         spec_d                = 1'b1;
         spec_res_d            = QNAN_W;
         spec_flags_d[FLG_INV] = 1'b1;
      end else if (a_cls == INF) begin
         spec_d     = 1'b1;
         spec_res_d = {a_sign, INF_MAG[W-2:0]};
      end else if (b_cls == INF) begin
         spec_d     = 1'b1;
         spec_res_d = {b_sign, INF_MAG[W-2:0]};
      end
   end

   logic             s1_valid, s1_spec, s1_sign, s1_eff_sub, s1_zero_sign;
   logic [W-1:0]     s1_spec_res;
   logic [3:0]       s1_spec_flags;
   logic [EXP_W-1:0] s1_exp;
   logic [AW-1:0]    s1_big, s1_small;

   // ---------------------------------------------------------------- S2
   logic [SUMW-1:0] sum_d;
   assign sum_d = s1_eff_sub ? ({1'b0, s1_big} - {1'b0, s1_small})
                             : ({1'b0, s1_big} + {1'b0, s1_small});

   logic             s2_valid, s2_spec, s2_sign, s2_zero_sign;
   logic [W-1:0]     s2_spec_res;
   logic [3:0]       s2_spec_flags;
   logic [EXP_W-1:0] s2_exp;
   logic [SUMW-1:0]  s2_sum;

   // ---------------------------------------------------------------- S3
   logic [CW-1:0]          lz;
   logic [EXP_W-1:0]       lim, sh;
   logic [EXP_W:0]         exp_n, exp_field, exp_f;
   logic [AW-1:0]          norm;
   logic [EXP_W+MAN_W:0]   pre, rounded;
   logic                   round_up, inexact, ovf, res_sign;
   logic [W-1:0]           res_d;
   logic [3:0]             flags_d;

   fp_lzc #(.WIDTH(LZW), .CNT_W(CW)) u_lzc (
      .din   (s2_sum[MAN_W+3:2]),
      .count (lz)
   );

   always_comb begin
      lim   = s2_exp - EXP_ONE;
      sh    = '0;
      norm  = s2_sum[AW-1:0];
      exp_n = {1'b0, s2_exp};
      if (s2_sum[SUMW-1]) begin
         norm  = {s2_sum[SUMW-1:2], s2_sum[1] | s2_sum[0]};
         exp_n = {1'b0, s2_exp} + EXPX_ONE;
      end else begin
         // Stop normalising at exponent 1; what remains is a subnormal.
         sh    = (int'(lz) < int'(lim)) ? EXP_W'(lz) : lim;
         norm  = s2_sum[AW-1:0] << sh;
         exp_n = {1'b0, s2_exp - sh};
      end

      exp_field = norm[AW-1] ? exp_n : '0;
      pre       = {exp_field, norm[MAN_W+2:3]};
      inexact   = |norm[2:0];
      round_up  = norm[2] & (norm[1] | norm[0] | norm[3]);
      // Adding into the packed {exp, frac} carries mantissa overflow into the exponent.
      rounded   = pre + {{(EXP_W + MAN_W){1'b0}}, round_up};
      exp_f     = rounded[EXP_W+MAN_W:MAN_W];
      ovf       = exp_f >= {1'b0, EXP_ONES};
      res_sign  = (s2_sum == '0) ? s2_zero_sign : s2_sign;

      res_d   = {res_sign, rounded[EXP_W+MAN_W-1:0]};
      flags_d = '0;
      if (s2_spec) begin
         res_d   = s2_spec_res;
         flags_d = s2_spec_flags;
      end else if (ovf) begin
         res_d            = {res_sign, INF_MAG[W-2:0]};
         flags_d[FLG_OVF] = 1'b1;
         flags_d[FLG_INX] = 1'b1;
      end else begin
         flags_d[FLG_INX] = inexact;
         flags_d[FLG_UNF] = inexact && (exp_f == '0);
      end
   end

   // ---------------------------------------------------------------- registers
   // NOTE: sequential state uses non-blocking assignments so all stages sample pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid     <= 1'b0;
         s2_valid     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_result_q <= '0;
         out_flags_q  <= '0;
      end else if (adv) begin
         s1_valid    <= bus.in_valid;
         s2_valid    <= s1_valid;
         out_valid_q <= s2_valid;
         if (s2_valid) begin
            out_result_q <= res_d;
            out_flags_q  <= flags_d;
         end
      end
   end

   // NOTE: inner datapath registers are left without reset; their per-stage valid bits make the contents don't-care.
   always_ff @(posedge clk) begin
      if (adv) begin
         s1_spec       <= spec_d;
         s1_spec_res   <= spec_res_d;
         s1_spec_flags <= spec_flags_d;
         s1_sign       <= l_sign;
         s1_eff_sub    <= a_sign ^ b_sign;
         s1_zero_sign  <= a_sign & b_sign;
         s1_exp        <= l_eexp;
         s1_big        <= big_d;
         s1_small      <= small_d;

         s2_spec       <= s1_spec;
         s2_spec_res   <= s1_spec_res;
         s2_spec_flags <= s1_spec_flags;
         s2_sign       <= s1_sign;
         s2_zero_sign  <= s1_zero_sign;
         s2_exp        <= s1_exp;
         s2_sum        <= sum_d;
      end
   end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// -----------------------------------------------------------------------------
// tb_fp_addsub_pipe
// Directed bench for fp_addsub_pipe (single precision) with hand-computed
// expected results: reset state, latency, zero signs, rounding, overflow,
// specials, subnormals, a stalled in-order stream and reset flush.
// -----------------------------------------------------------------------------
module tb_fp_addsub_pipe;
   import fp_pkg::*;

   localparam int EXP_W = 8;
   localparam int MAN_W = 23;
   localparam int W     = 32;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         op;
      logic [W-1:0] res;
      logic [3:0]   flags;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;

   fp_addsub_pipe_if #(.EXP_W(EXP_W), .MAN_W(MAN_W)) bus ();

   fp_addsub_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Issues one operation (called just after a falling edge) and returns the
   // result once out_valid rises, plus the cycles counted from acceptance.
   task automatic send_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                           output logic [W-1:0] res, output logic [3:0] flg, output int lat);
      int guard;
      bus.in_a      = a;
      bus.in_b      = b;
      bus.in_op     = op;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      guard = 0;
      while (!bus.in_ready && guard < 20) begin
         @(negedge clk); #1; guard++;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      lat = 1;
      #1;
      while (!bus.out_valid && lat < 10) begin
         @(negedge clk); #1; lat++;
      end
      res = bus.out_result;
      flg = bus.out_flags;
   endtask

   // Runs a table of directed vectors, comparing result and flags inline.
   task automatic run_table(input string name, input vec_t v[]);
      logic [W-1:0] res;
      logic [3:0]   flg;
      int           lat;
      foreach (v[i]) begin
         send_one(v[i].a, v[i].b, v[i].op, res, flg, lat);
         checks++;
         if (res !== v[i].res) begin
            failures++;
            $display("FAIL %s[%0d] result got=%h want=%h", name, i, res, v[i].res);
         end
         checks++;
         if (flg !== v[i].flags) begin
            failures++;
            $display("FAIL %s[%0d] flags got=%b want=%b", name, i, flg, v[i].flags);
         end
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_op     = 1'b0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
      checks++;
      if (bus.out_result !== 32'h0) begin failures++; $display("FAIL reset_out_result got=%h want=00000000", bus.out_result); end
      checks++;
      if (bus.out_flags !== 4'h0) begin failures++; $display("FAIL reset_out_flags got=%b want=0000", bus.out_flags); end
      checks++;
      if (bus.in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_latency();
      logic [W-1:0] res;
      logic [3:0]   flg;
      int           lat;
      send_one(32'h3F800000, 32'h3F800000, 1'b0, res, flg, lat);
      checks++;
      if (lat != 3) begin failures++; $display("FAIL latency cycles got=%0d want=3", lat); end
      checks++;
      if (res !== 32'h40000000) begin failures++; $display("FAIL one_plus_one result got=%h want=40000000", res); end
      checks++;
      if (flg !== 4'b0000) begin failures++; $display("FAIL one_plus_one flags got=%b want=0000", flg); end
   endtask

   task automatic test_zero_sign();
      vec_t v[] = '{
         '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000},  // 1-1 = +0
         '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000},  // -0 + -0
         '{32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 4'b0000},  // -0 - +0
         '{32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000}   // +0 + -0
      };
      run_table("zero_sign", v);
   endtask

   task automatic test_rounding();
      vec_t v[] = '{
         '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001},  // tie, even stays
         '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001},  // tie, odd rounds up
         '{32'h3F800000, 32'h33800000, 1'b1, 32'h3F7FFFFF, 4'b0000}   // 1 - 2^-24 exact
      };
      run_table("rounding", v);
   endtask

   task automatic test_overflow_specials();
      vec_t v[] = '{
         '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101},  // +max + +max
         '{32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 32'hFF800000, 4'b0101},  // -max + -max
         '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000},  // Inf - Inf
         '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b1000},  // sNaN input
         '{32'h3F800000, 32'hFFC00000, 1'b0, 32'h7FC00000, 4'b0000},  // qNaN input
         '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000},  // Inf + 1
         '{32'h3F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000}   // 1 - (-Inf)
      };
      run_table("specials", v);
   endtask

   task automatic test_subnormal();
      vec_t v[] = '{
         '{32'h00000001, 32'h00000001, 1'b0, 32'h00000002, 4'b0000},
         '{32'h00800000, 32'h00000001, 1'b1, 32'h007FFFFF, 4'b0000},
         '{32'h007FFFFF, 32'h00000001, 1'b0, 32'h00800000, 4'b0000}
      };
      run_table("subnormal", v);
   endtask

   // Eight back-to-back ops with the consumer stalled for 5 cycles mid-stream.
   task automatic test_stream_stall();
      vec_t v[8] = '{
         '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000},  // 1 + 2 = 3
         '{32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 4'b0000},  // 3 - 1 = 2
         '{32'h40A00000, 32'hC0600000, 1'b0, 32'h3FC00000, 4'b0000},  // 5 + -3.5 = 1.5
         '{32'h41200000, 32'h41A00000, 1'b1, 32'hC1200000, 4'b0000},  // 10 - 20 = -10
         '{32'hC0000000, 32'hC0800000, 1'b0, 32'hC0C00000, 4'b0000},  // -2 + -4 = -6
         '{32'h3F000000, 32'h3E800000, 1'b1, 32'h3E800000, 4'b0000},  // 0.5 - 0.25
         '{32'h42C80000, 32'h3F800000, 1'b0, 32'h42CA0000, 4'b0000},  // 100 + 1 = 101
         '{32'h3F800000, 32'h3FC00000, 1'b1, 32'hBF000000, 4'b0000}   // 1 - 1.5 = -0.5
      };
      int  tx  = 0;
      int  rx  = 0;
      int  cyc = 0;
      logic stall;
      while (rx < 8 && cyc < 60) begin
         @(negedge clk);
         stall         = (cyc >= 5) && (cyc < 10);
         bus.out_ready = !stall;
         bus.in_valid  = (tx < 8);
         if (tx < 8) begin
            bus.in_a  = v[tx].a;
            bus.in_b  = v[tx].b;
            bus.in_op = v[tx].op;
         end
         #1;
         if (stall && bus.out_valid) begin
            checks++;
            if (bus.in_ready !== 1'b0) begin
               failures++;
               $display("FAIL stall_in_ready cycle=%0d got=%b want=0", cyc, bus.in_ready);
            end
         end
         if (bus.out_valid && bus.out_ready) begin
            checks++;
            if (bus.out_result !== v[rx].res || bus.out_flags !== v[rx].flags) begin
               failures++;
               $display("FAIL stream[%0d] got=%h/%b want=%h/%b", rx, bus.out_result,
                        bus.out_flags, v[rx].res, v[rx].flags);
            end
            rx++;
         end
         if (bus.in_valid && bus.in_ready) tx++;
         cyc++;
      end
      checks++;
      if (rx != 8) begin failures++; $display("FAIL stream_count got=%0d want=8", rx); end
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Two ops in flight, then an asynchronous reset pulse must discard them.
   task automatic test_reset_flush();
      int seen = 0;
      bus.out_ready = 1'b1;
      bus.in_a      = 32'h3F800000;
      bus.in_b      = 32'h3F800000;
      bus.in_op     = 1'b0;
      bus.in_valid  = 1'b1;
      @(negedge clk);
      bus.in_a = 32'h40000000;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_async out_valid got=%b want=0", bus.out_valid); end
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin failures++; $display("FAIL flush_next out_valid got=%b want=0", bus.out_valid); end
      rst_n = 1'b1;
      repeat (6) begin
         @(negedge clk);
         #1;
         if (bus.out_valid) seen++;
      end
      checks++;
      if (seen != 0) begin failures++; $display("FAIL flush_stale results got=%0d want=0", seen); end
      checks++;
      if (bus.out_result !== 32'h0) begin failures++; $display("FAIL flush_result got=%h want=00000000", bus.out_result); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_zero_sign();
      test_rounding();
      test_overflow_specials();
      test_subnormal();
      @(negedge clk);
      test_stream_stall();
      test_reset_flush();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
